// File: rtl/sd_cmd_host_px.sv
// SD command-line host: serialises a 40-bit command with CRC7 and stop bit,
// then optionally captures and checks a 48- or 136-bit response.
module sd_cmd_host_px #(
    parameter int unsigned RESP_MAX    = 136,
    parameter int unsigned INIT_CYCLES = 64,
    parameter int unsigned NCR_MIN     = 2,
    parameter int unsigned NCR_MAX     = 64,
    parameter int unsigned NCC         = 8
) (
    input  logic                SD_CLK_IN,
    input  logic                RST_IN,
    input  logic                GO_IDLE,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [39:0]         cmd_i,
    input  logic [7:0]          resp_len_i,
    input  logic                crc_chk_i,
    output logic                resp_valid_o,
    output logic [RESP_MAX-1:0] resp_o,
    output logic                crc_err_o,
    output logic                end_err_o,
    output logic                timeout_o,
    input  logic                cmd_dat_i,
    output logic                cmd_out_o,
    output logic                cmd_oe_o
);

    localparam int unsigned CW = 16;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_SEND, S_WAIT, S_RECV, S_CHECK, S_DONE, S_TURN
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [46:0]         tx_q, tx_d;
    logic [7:0]          len_q, len_d;
    logic                chk_q, chk_d;
    logic [RESP_MAX-1:0] sh_q, sh_d;
    logic [6:0]          rxcrc_q, rxcrc_d;
    logic [RESP_MAX-1:0] resp_q, resp_d;
    logic                crc_err_q, crc_err_d;
    logic                end_err_q, end_err_d;
    logic                timeout_q, timeout_d;
    logic                out_q, out_d;
    logic                oe_q, oe_d;
    logic [7:0]          top;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0]  c;
        logic [39:0] s;
        c = '0;
        s = d;
        for (int unsigned i = 0; i < 40; i++) begin
            c = crc7_step(c, s[39]);
            s = s << 1;
        end
        return c;
    endfunction

    function automatic logic [7:0] norm_len(input logic [7:0] l);
        if (l == 8'd0)                 return 8'd0;
        else if (l <= 8'd48)           return 8'd48;
        else if (32'(l) <= RESP_MAX)   return 8'd136;
        else                           return 8'(RESP_MAX);
    endfunction

    // State and datapath registers; reset wins over everything.
    always_ff @(posedge SD_CLK_IN) begin
        if (RST_IN) begin
            state_q   <= S_INIT;
            cnt_q     <= '0;
            tx_q      <= '0;
            len_q     <= '0;
            chk_q     <= 1'b0;
            sh_q      <= '0;
            rxcrc_q   <= '0;
            resp_q    <= '0;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
            timeout_q <= 1'b0;
            out_q     <= 1'b1;
            oe_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_q      <= tx_d;
            len_q     <= len_d;
            chk_q     <= chk_d;
            sh_q      <= sh_d;
            rxcrc_q   <= rxcrc_d;
            resp_q    <= resp_d;
            crc_err_q <= crc_err_d;
            end_err_q <= end_err_d;
            timeout_q <= timeout_d;
            out_q     <= out_d;
            oe_q      <= oe_d;
        end
    end

    // Next-state, line control and response capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        len_d     = len_q;
        chk_d     = chk_q;
        sh_d      = sh_q;
        rxcrc_d   = rxcrc_q;
        resp_d    = resp_q;
        crc_err_d = crc_err_q;
        end_err_d = end_err_q;
        timeout_d = timeout_q;
        out_d     = out_q;
        oe_d      = oe_q;
        top       = (len_q == 8'd48) ? 8'd47 : 8'd127;

        case (state_q)
            S_INIT: begin
                oe_d  = 1'b1;
                out_d = 1'b1;
                if (cnt_q >= CW'(INIT_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    oe_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                oe_d = 1'b0;
                if (cmd_valid_i) begin
                    tx_d      = {cmd_i[38:0], crc7_40(cmd_i), 1'b1};
                    len_d     = norm_len(resp_len_i);
                    chk_d     = crc_chk_i;
                    out_d     = cmd_i[39];
                    oe_d      = 1'b1;
                    cnt_d     = CW'(47);
                    crc_err_d = 1'b0;
                    end_err_d = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                // cnt_q is the index of the frame bit currently on the line
                if (cnt_q == '0) begin
                    oe_d    = 1'b0;
                    out_d   = 1'b1;
                    cnt_d   = CW'(1);
                    state_d = (len_q == 8'd0) ? S_TURN : S_WAIT;
                end else begin
                    out_d = tx_q[46];
                    tx_d  = {tx_q[45:0], 1'b0};
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WAIT: begin
                oe_d = 1'b0;
                if (cnt_q > CW'(NCR_MIN) && !cmd_dat_i) begin
                    sh_d    = '0;
                    rxcrc_d = '0;
                    cnt_d   = CW'(len_q) - CW'(2);
                    state_d = S_RECV;
                end else if (cnt_q >= CW'(NCR_MAX)) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RECV: begin
                // cnt_q is the frame position of the bit sampled this cycle
                sh_d = {sh_q[RESP_MAX-2:0], cmd_dat_i};
                if (cnt_q >= CW'(8) && cnt_q <= CW'(top))
                    rxcrc_d = crc7_step(rxcrc_q, cmd_dat_i);
                if (cnt_q == '0) state_d = S_CHECK;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_CHECK: begin
                resp_d    = sh_q;
                crc_err_d = chk_q & (rxcrc_q != sh_q[7:1]);
                end_err_d = ~sh_q[0];
                state_d   = S_DONE;
            end
            S_DONE: begin
                cnt_d   = CW'(1);
                state_d = (len_q == 8'd0) ? S_IDLE : S_TURN;
            end
            S_TURN: begin
                oe_d = 1'b0;
                if (cnt_q >= CW'(NCC)) state_d = (len_q == 8'd0) ? S_DONE : S_IDLE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides the above but keeps the last reported result
        if (GO_IDLE) begin
            state_d   = S_IDLE;
            oe_d      = 1'b0;
            out_d     = 1'b0;
            cnt_d     = '0;
            resp_d    = resp_q;
            crc_err_d = crc_err_q;
            end_err_d = end_err_q;
            timeout_d = timeout_q;
        end
    end

    assign cmd_ready_o  = (state_q == S_IDLE);
    assign resp_valid_o = (state_q == S_DONE);
    assign resp_o       = resp_q;
    assign crc_err_o    = crc_err_q;
    assign end_err_o    = end_err_q;
    assign timeout_o    = timeout_q;
    assign cmd_out_o    = out_q;
    assign cmd_oe_o     = oe_q;

endmodule

// File: tb/tb_sd_cmd_host_px.sv
// Bench for sd_cmd_host_px: card emulation plus queue-based scoreboard.
module tb_sd_cmd_host_px;

    logic         SD_CLK_IN = 1'b0;
    logic         RST_IN = 1'b1, GO_IDLE = 1'b0;
    logic         cmd_valid_i = 1'b0, cmd_ready_o;
    logic [39:0]  cmd_i = '0;
    logic [7:0]   resp_len_i = '0;
    logic         crc_chk_i = 1'b0;
    logic         resp_valid_o;
    logic [135:0] resp_o;
    logic         crc_err_o, end_err_o, timeout_o;
    logic         cmd_dat_i = 1'b1, cmd_out_o, cmd_oe_o;

    typedef struct {
        logic [135:0] resp;
        logic         crc_err;
        logic         end_err;
        logic         timeout;
    } exp_t;

    exp_t         expq[$];
    logic [47:0]  txq[$];
    logic [135:0] last_resp = '0;
    int           checks = 0, errors = 0;

    always #5 SD_CLK_IN = ~SD_CLK_IN;

    sd_cmd_host_px #(
        .RESP_MAX(136), .INIT_CYCLES(64), .NCR_MIN(2), .NCR_MAX(64), .NCC(8)
    ) dut (
        .SD_CLK_IN(SD_CLK_IN), .RST_IN(RST_IN), .GO_IDLE(GO_IDLE),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_i(cmd_i),
        .resp_len_i(resp_len_i), .crc_chk_i(crc_chk_i), .resp_valid_o(resp_valid_o),
        .resp_o(resp_o), .crc_err_o(crc_err_o), .end_err_o(end_err_o),
        .timeout_o(timeout_o), .cmd_dat_i(cmd_dat_i), .cmd_out_o(cmd_out_o),
        .cmd_oe_o(cmd_oe_o)
    );

    task automatic compare(input string name, input logic [135:0] act, input logic [135:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // CRC7 as the remainder of long division by x^7+x^3+1 over bits hi..lo.
    function automatic logic [6:0] ref_crc7(input logic [135:0] f, input int hi, input int lo);
        logic [142:0] m;
        logic [7:0]   poly;
        int           n;
        poly = 8'h89;
        m = '0;
        n = hi - lo + 1;
        for (int i = 0; i < n; i++) m[i+7] = f[lo+i];
        for (int i = n + 6; i >= 7; i--)
            if (m[i]) for (int j = 0; j < 8; j++) m[i-7+j] = m[i-7+j] ^ poly[j];
        return m[6:0];
    endfunction

    function automatic int norm_len(input int l);
        if (l == 0) return 0;
        if (l <= 48) return 48;
        return 136;
    endfunction

    function automatic logic [135:0] make_frame(input int l, input bit good, input bit endb);
        logic [159:0] r;
        logic [135:0] f;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        f = r[135:0];
        if (l == 48) begin
            f[135:48] = '0;
            f[47] = 1'b0;
        end else begin
            f[135] = 1'b0;
        end
        f[7:1] = good ? ref_crc7(f, (l == 48) ? 47 : 127, 8) : 7'(r[150:144]);
        f[0] = endb;
        return f;
    endfunction

    // Issues one command and plays the card side of the exchange.
    task automatic issue(input logic [39:0] cmd, input logic [7:0] len, input logic chk,
                         input bit respond, input logic [135:0] frame, input int dly,
                         input bit pre_low, input bit push, input int abort_at);
        int           l, n;
        logic [135:0] cf;
        exp_t         e;
        l = norm_len(int'(len));
        if (push) begin
            cf = '0;
            cf[47:8] = cmd;
            txq.push_back({cmd, ref_crc7(cf, 47, 8), 1'b1});
            if (abort_at == 0) begin
                e.resp = last_resp; e.crc_err = 1'b0; e.end_err = 1'b0; e.timeout = 1'b0;
                if (l != 0 && respond) begin
                    e.resp    = frame;
                    e.crc_err = chk && (ref_crc7(frame, (l == 48) ? 47 : 127, 8) != frame[7:1]);
                    e.end_err = ~frame[0];
                    last_resp = frame;
                end else if (l != 0) begin
                    e.timeout = 1'b1;
                end
                expq.push_back(e);
            end
        end
        @(posedge SD_CLK_IN); #1;
        cmd_i = cmd; resp_len_i = len; crc_chk_i = chk; cmd_valid_i = 1'b1;
        n = 0;
        forever begin
            @(negedge SD_CLK_IN);
            if (cmd_ready_o) break;
            n++;
            if (n > 2000) begin
                compare("ready_wait_expired", 136'(cmd_ready_o), 136'(1));
                cmd_valid_i = 1'b0;
                return;
            end
        end
        @(posedge SD_CLK_IN); #1;
        cmd_valid_i = 1'b0;
        if (l == 0) return;
        if (pre_low) begin
            repeat (48) @(posedge SD_CLK_IN);
            #1 cmd_dat_i = 1'b0;
            @(posedge SD_CLK_IN); #1;
            @(posedge SD_CLK_IN); #1 cmd_dat_i = 1'b1;
        end
        if (!respond) return;
        repeat (47 + dly - (pre_low ? 50 : 0)) @(posedge SD_CLK_IN);
        #1;
        for (int i = l - 1; i >= 0; i--) begin
            cmd_dat_i = frame[i];
            @(posedge SD_CLK_IN); #1;
            if (abort_at > 0 && (l - 1 - i) == abort_at) begin
                GO_IDLE = 1'b1;
                @(posedge SD_CLK_IN); #1;
                GO_IDLE = 1'b0;
                compare("abort_ready", 136'(cmd_ready_o), 136'(1));
                compare("abort_oe", 136'(cmd_oe_o), 136'(0));
                compare("abort_out", 136'(cmd_out_o), 136'(0));
                compare("abort_resp_kept", resp_o, last_resp);
                compare("abort_flags", 136'({crc_err_o, end_err_o, timeout_o}), 136'(0));
                break;
            end
        end
        cmd_dat_i = 1'b1;
    endtask

    task automatic init_count(input string name);
        int n;
        n = 0;
        forever begin
            @(negedge SD_CLK_IN);
            if (!(cmd_oe_o && cmd_out_o) || n > 1000) break;
            n++;
        end
        compare(name, 136'(n), 136'(64));
        compare("init_ready", 136'(cmd_ready_o), 136'(1));
        compare("init_oe", 136'(cmd_oe_o), 136'(0));
    endtask

    // Transmit monitor: captures the 48 line bits following each handshake.
    initial begin : mon_tx
        logic [47:0] fexp, got;
        logic        oe_all;
        forever begin
            @(negedge SD_CLK_IN);
            if (!RST_IN && !GO_IDLE && cmd_valid_i && cmd_ready_o && txq.size() > 0) begin
                fexp = txq.pop_front();
                oe_all = 1'b1;
                for (int i = 47; i >= 0; i--) begin
                    @(negedge SD_CLK_IN);
                    got[i] = cmd_out_o;
                    oe_all = oe_all & cmd_oe_o;
                end
                compare("tx_frame", 136'(got), 136'(fexp));
                compare("tx_oe", 136'(oe_all), 136'(1));
            end
        end
    end

    // Completion monitor: every resp_valid_o pulse must match the queue head.
    initial begin : mon_rsp
        exp_t e;
        forever begin
            @(negedge SD_CLK_IN);
            if (resp_valid_o) begin
                if (expq.size() == 0) begin
                    compare("unexpected_resp_valid", 136'(resp_valid_o), 136'(0));
                end else begin
                    e = expq.pop_front();
                    compare("resp_o", resp_o, e.resp);
                    compare("crc_err", 136'(crc_err_o), 136'(e.crc_err));
                    compare("end_err", 136'(end_err_o), 136'(e.end_err));
                    compare("timeout", 136'(timeout_o), 136'(e.timeout));
                    @(negedge SD_CLK_IN);
                    compare("resp_valid_width", 136'(resp_valid_o), 136'(0));
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: run did not complete, got hang required finish");
        $fatal(1);
    end

    initial begin : main
        logic [63:0]  r;
        logic [135:0] f;
        int           sel, len, l, dly;

        repeat (3) @(posedge SD_CLK_IN);
        @(negedge SD_CLK_IN);
        compare("rst_oe_out", 136'({cmd_oe_o, cmd_out_o}), 136'(2'b11));
        compare("rst_ready_valid", 136'({cmd_ready_o, resp_valid_o}), 136'(0));
        compare("rst_resp", resp_o, '0);
        compare("rst_flags", 136'({crc_err_o, end_err_o, timeout_o}), 136'(0));
        @(posedge SD_CLK_IN); #1 RST_IN = 1'b0;
        init_count("init_cycles");

        // CMD0, no response
        issue(40'h4000000000, 8'd0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b1, 0);
        // CMD17, short response, good CRC then corrupted CRC with and without checking
        f = 136'h110000090067;
        issue(40'h5100000000, 8'd48, 1'b1, 1'b1, f, 5, 1'b0, 1'b1, 0);
        issue(40'h5100000000, 8'd48, 1'b1, 1'b1, f ^ 136'h8, 5, 1'b0, 1'b1, 0);
        issue(40'h5100000000, 8'd48, 1'b0, 1'b1, f ^ 136'h8, 5, 1'b0, 1'b1, 0);
        // CMD8 with no card answer; an early low must be ignored
        issue(40'h48000001AA, 8'd48, 1'b1, 1'b0, '0, 0, 1'b1, 1'b1, 0);
        // Long response with valid CRC
        f = make_frame(136, 1'b1, 1'b1);
        issue(40'h4200000000, 8'd136, 1'b1, 1'b1, f, 4, 1'b0, 1'b1, 0);
        // Long response aborted mid-receive
        f = make_frame(136, 1'b1, 1'b1);
        issue(40'h4200000000, 8'd136, 1'b1, 1'b1, f, 4, 1'b0, 1'b1, 20);

        // GO_IDLE together with cmd_valid_i must not be accepted
        @(posedge SD_CLK_IN); #1;
        GO_IDLE = 1'b1; cmd_valid_i = 1'b1;
        @(posedge SD_CLK_IN); #1;
        GO_IDLE = 1'b0; cmd_valid_i = 1'b0;
        @(negedge SD_CLK_IN);
        compare("goidle_valid_ready", 136'(cmd_ready_o), 136'(1));
        compare("goidle_valid_oe", 136'(cmd_oe_o), 136'(0));

        // Reset in the middle of a transmission
        issue(40'h4000000000, 8'd0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0, 0);
        repeat (10) @(posedge SD_CLK_IN);
        #1 RST_IN = 1'b1;
        @(posedge SD_CLK_IN); #1 RST_IN = 1'b0;
        last_resp = '0;
        compare("midrst_oe_out", 136'({cmd_oe_o, cmd_out_o}), 136'(2'b11));
        compare("midrst_ready", 136'(cmd_ready_o), 136'(0));
        compare("midrst_resp", resp_o, '0);
        compare("midrst_flags", 136'({crc_err_o, end_err_o, timeout_o}), 136'(0));
        init_count("init_cycles_after_rst");

        // Randomised traffic
        for (int k = 0; k < 24; k++) begin
            sel = $urandom_range(0, 3);
            len = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(1, 48) :
                  (sel == 2) ? $urandom_range(49, 136) : $urandom_range(137, 255);
            l   = norm_len(len);
            dly = (k % 5 == 0) ? 3 : (k % 5 == 1) ? 63 : $urandom_range(3, 40);
            r   = {$urandom, $urandom};
            f   = (l == 0) ? '0 : make_frame(l, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
            issue(r[39:0], 8'(len), 1'($urandom_range(0, 1)), $urandom_range(0, 5) != 0,
                  f, dly, 1'b0, 1'b1, 0);
        end

        repeat (300) @(posedge SD_CLK_IN);
        compare("expq_drained", 136'(expq.size()), 136'(0));
        compare("txq_drained", 136'(txq.size()), 136'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
